// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant encoding and
// the starvation counter width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } arb_gnt_e;

  // Bits needed to hold 0..starve_max inclusive.
  function automatic int starve_cnt_w(input int starve_max);
    return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
// Clear has priority over increment.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = starve_cnt_w(MAX)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory between instruction fetch and data ports.
// Data wins by default; a starvation counter forces a fetch grant eventually.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output arb_state_e        dbg_state
);

  // Handshake: a requester raises if_req or dm_read/dm_write and holds it,
  // with stable address/data, until its one-cycle ready pulse; the arbiter
  // samples requests only in IDLE, so the request and ready cycle never overlap
  // with a new grant for the same access.

  arb_state_e            state_q, state_d;
  arb_gnt_e              gnt_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  dm_pend, pick_if, grant;
  logic                  sat, cnt_inc, cnt_clr;

  assign dm_pend = dm_read | dm_write;
  assign pick_if = if_req && (!dm_pend || sat);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (dm_pend || if_req) begin
          grant   = 1'b1;
          state_d = ARB_BUSY;
          cnt_inc = !pick_if && if_req;
          cnt_clr = pick_if || !if_req;
        end
      end
      ARB_BUSY: if (mem_ack) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Issue registers: the memory side never sees the requesters directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q   <= GNT_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err     <= 1'b0;
    end else if (grant) begin
      gnt_q   <= pick_if ? GNT_IF : GNT_DM;
      we_q    <= !pick_if && dm_write;
      addr_q  <= pick_if ? if_addr : dm_addr;
      wdata_q <= pick_if ? '0 : dm_wdata;
      if (dm_read && dm_write) err <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (state_q == ARB_BUSY && mem_ack) begin
      if (gnt_q == GNT_IF) if_rdata <= mem_rdata;
      else if (!we_q)      dm_rdata <= mem_rdata;
    end
  end

  arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .sat     (sat)
  );

  assign mem_req   = (state_q == ARB_BUSY);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = (state_q == ARB_RESP) && (gnt_q == GNT_IF);
  assign dm_ready  = (state_q == ARB_RESP) && (gnt_q == GNT_DM);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int SMAX = 4;

  logic        clock, reset_n;
  logic        if_req, dm_read, dm_write, mem_req, mem_we, mem_ack;
  logic        if_ready, dm_ready, err;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  arb_state_e  dbg_state;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [95:0] exp_q[$];
  logic [31:0] mem_model[logic [31:0]];
  int          m_starve;
  logic [31:0] m_if_rdata, m_dm_rdata;

  logic        obs_ok, obs_we, obs_ifr, obs_dmr;
  logic [31:0] obs_addr, obs_wdata;
  int          obs_busy;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic drop_all();
    if_req = 0; dm_read = 0; dm_write = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0; drop_all(); mem_ack = 0; mem_rdata = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clock);
    reset_n = 1;
    m_starve = 0; m_if_rdata = '0; m_dm_rdata = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, dbg_state, ARB_IDLE);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_if_ready"}, if_ready, 0);
    check({tag, "_dm_ready"}, dm_ready, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_dm_rdata"}, dm_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at an IDLE negedge with requests already driven; returns at the
  // negedge of the RESP cycle with the observed issue and ready values.
  task automatic do_access(input int dly, input logic [31:0] rd);
    int n;
    obs_ok = 0; obs_busy = 0;
    @(negedge clock);
    n = 0;
    while (!mem_req && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (!mem_req) begin
      check("mem_req_timeout", 0, 1);
      return;
    end
    obs_ok = 1; obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
    for (int i = 0; i < dly; i++) begin
      if (mem_req) obs_busy++;
      @(negedge clock);
    end
    if (mem_req) obs_busy++;
    mem_ack = 1; mem_rdata = rd;
    @(negedge clock);
    mem_ack = 0; mem_rdata = $urandom;
    obs_ifr = if_ready; obs_dmr = dm_ready;
  endtask

  task automatic after_resp(input string tag);
    @(negedge clock);
    check({tag, "_if_ready_low"}, if_ready, 0);
    check({tag, "_dm_ready_low"}, dm_ready, 0);
    check({tag, "_idle_no_req"}, mem_req, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_read, dm_write;
    logic [31:0] dm_addr, dm_wdata;
    int          dly;
    logic [31:0] rd;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic        exp_ifr, exp_dmr;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    logic        if_p, dm_p, dm_we_v, win_dm, seen;
    logic [31:0] if_a, dm_a, dm_wd, rd, exp_addr;
    logic [95:0] e;
    int          dly;

    // Fetch-only, write/read, contention with fresh counter, data write under fetch.
    vecs[0] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        2, 32'h8C08_0004,
                1'b0, 32'h40,  1'b1, 1'b0, 32'h8C08_0004, 32'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1, 32'h5555_AAAA,
                1'b1, 32'h100, 1'b0, 1'b1, 32'h8C08_0004, 32'h0};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h0,        0, 32'hDEAD_BEEF,
                1'b0, 32'h100, 1'b0, 1'b1, 32'h8C08_0004, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h44,  1'b1, 1'b0, 32'h104, 32'h0,        3, 32'h1111_2222,
                1'b0, 32'h104, 1'b0, 1'b1, 32'h8C08_0004, 32'h1111_2222};
    vecs[4] = '{1'b1, 32'h48,  1'b0, 1'b0, 32'h0,   32'h0,        0, 32'h0000_0013,
                1'b0, 32'h48,  1'b1, 1'b0, 32'h0000_0013, 32'h1111_2222};
    vecs[5] = '{1'b1, 32'h4C,  1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 2, 32'h7777_7777,
                1'b1, 32'h200, 1'b0, 1'b1, 32'h0000_0013, 32'h1111_2222};

    apply_reset();
    check_reset_vals("reset");

    for (int v = 0; v < 6; v++) begin
      if_req = vecs[v].if_req; if_addr = vecs[v].if_addr;
      dm_read = vecs[v].dm_read; dm_write = vecs[v].dm_write;
      dm_addr = vecs[v].dm_addr; dm_wdata = vecs[v].dm_wdata;
      do_access(vecs[v].dly, vecs[v].rd);
      if (obs_ok) begin
        check($sformatf("vec%0d_addr", v), obs_addr, vecs[v].exp_addr);
        check($sformatf("vec%0d_we", v), obs_we, vecs[v].exp_we);
        if (vecs[v].exp_we) check($sformatf("vec%0d_wdata", v), obs_wdata, vecs[v].dm_wdata);
        check($sformatf("vec%0d_busy_cycles", v), obs_busy, vecs[v].dly + 1);
        check($sformatf("vec%0d_if_ready", v), obs_ifr, vecs[v].exp_ifr);
        check($sformatf("vec%0d_dm_ready", v), obs_dmr, vecs[v].exp_dmr);
        check($sformatf("vec%0d_if_rdata", v), if_rdata, vecs[v].exp_if_rdata);
        check($sformatf("vec%0d_dm_rdata", v), dm_rdata, vecs[v].exp_dm_rdata);
      end
      drop_all();
      after_resp($sformatf("vec%0d", v));
    end

    // Spurious ack while idle must not disturb anything.
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clock);
      check("spur_state", dbg_state, ARB_IDLE);
      check("spur_ready", {if_ready, dm_ready}, 2'b00);
    end
    mem_ack = 0;
    check("spur_if_rdata", if_rdata, 32'h0000_0013);
    check("spur_dm_rdata", dm_rdata, 32'h1111_2222);

    // Read and write together: issued as a write, sticky err.
    dm_read = 1; dm_write = 1; dm_addr = 32'h180; dm_wdata = 32'h1234_5678;
    do_access(0, 32'hABCD_0000);
    check("proto_we", obs_we, 1);
    check("proto_wdata", obs_wdata, 32'h1234_5678);
    check("proto_err", err, 1);
    check("proto_dm_rdata_kept", dm_rdata, 32'h1111_2222);
    drop_all();
    after_resp("proto");
    if_req = 1; if_addr = 32'h50;
    do_access(1, 32'h0000_0093);
    if_req = 0;
    after_resp("proto_fetch");
    check("proto_err_sticky", err, 1);
    apply_reset();
    check_reset_vals("reset2");

    // Reset while BUSY drops mem_req at once; a late ack is ignored.
    if_req = 1; if_addr = 32'h60;
    @(negedge clock);
    @(negedge clock);
    check("midrst_busy_req", mem_req, 1);
    #2 reset_n = 0;
    #1 check("midrst_req_drop", mem_req, 0);
    check("midrst_state", dbg_state, ARB_IDLE);
    if_req = 0;
    @(negedge clock);
    reset_n = 1;
    mem_ack = 1; mem_rdata = 32'hDEAD_0000;
    @(negedge clock);
    mem_ack = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (if_ready || dm_ready || mem_req) seen = 1;
      @(negedge clock);
    end
    check("midrst_late_ack_ignored", seen, 0);
    check("midrst_if_rdata", if_rdata, 0);
    if_req = 1; if_addr = 32'h64;
    do_access(1, 32'hA0A0_A0A0);
    check("midrst_fresh_addr", obs_addr, 32'h64);
    check("midrst_fresh_ready", obs_ifr, 1);
    check("midrst_fresh_rdata", if_rdata, 32'hA0A0_A0A0);
    if_req = 0;
    after_resp("midrst");

    // Contention: both held, immediate acks; order follows starvation rule.
    apply_reset();
    if_req = 1; if_addr = 32'h200; dm_read = 1; dm_addr = 32'h300;
    for (int t = 0; t < 10; t++) begin
      win_dm = (m_starve != SMAX);
      m_starve = win_dm ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
      rd = $urandom;
      if (win_dm) m_dm_rdata = rd; else m_if_rdata = rd;
      do_access(0, rd);
      if (!obs_ok) break;
      check($sformatf("cont%0d_grant_addr", t), obs_addr, win_dm ? 32'h300 : 32'h200);
      check($sformatf("cont%0d_ready", t), {obs_ifr, obs_dmr}, {!win_dm, win_dm});
      check($sformatf("cont%0d_rdata", t), {if_rdata, dm_rdata}, {m_if_rdata, m_dm_rdata});
      after_resp($sformatf("cont%0d", t));
    end
    drop_all();

    // Randomized traffic against the transaction-level model.
    apply_reset();
    if_p = 0; dm_p = 0; dm_we_v = 0; if_a = '0; dm_a = '0; dm_wd = '0;
    for (int t = 0; t < 60; t++) begin
      if (!if_p && $urandom_range(0, 1) == 1) begin
        if_p = 1; if_a = 32'($urandom_range(0, 15)) * 4;
      end
      if (!dm_p && $urandom_range(0, 1) == 1) begin
        dm_p = 1; dm_we_v = ($urandom_range(0, 2) == 0);
        dm_a = 32'($urandom_range(0, 15)) * 4; dm_wd = $urandom;
      end
      if (!if_p && !dm_p) begin
        if_p = 1; if_a = 32'($urandom_range(0, 15)) * 4;
      end
      if_req = if_p; if_addr = if_a;
      dm_read = dm_p && !dm_we_v; dm_write = dm_p && dm_we_v;
      dm_addr = dm_a; dm_wdata = dm_wd;

      win_dm = dm_p && !(if_p && m_starve == SMAX);
      if (win_dm) m_starve = if_p ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
      else        m_starve = 0;
      exp_addr = win_dm ? dm_a : if_a;
      exp_q.push_back({31'h0, win_dm && dm_we_v, exp_addr, (win_dm && dm_we_v) ? dm_wd : 32'h0});
      if (win_dm && dm_we_v) begin
        mem_model[dm_a] = dm_wd;
        rd = $urandom;
      end else begin
        rd = mem_rd(exp_addr);
        if (win_dm) m_dm_rdata = rd; else m_if_rdata = rd;
      end
      dly = $urandom_range(0, 3);
      do_access(dly, rd);
      e = exp_q.pop_front();
      if (!obs_ok) break;
      check($sformatf("rand%0d_issue", t),
            {31'h0, obs_we, obs_addr, obs_we ? obs_wdata : 32'h0}, e);
      check($sformatf("rand%0d_busy", t), obs_busy, dly + 1);
      check($sformatf("rand%0d_ready", t), {obs_ifr, obs_dmr}, {!win_dm, win_dm});
      check($sformatf("rand%0d_rdata", t), {if_rdata, dm_rdata}, {m_if_rdata, m_dm_rdata});
      if (win_dm) begin
        dm_p = 0; dm_read = 0; dm_write = 0;
      end else begin
        if_p = 0; if_req = 0;
      end
      after_resp($sformatf("rand%0d", t));
    end
    check("rand_no_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port unified memory between the pipeline's instruction-fetch port and its data-memory port, replacing the separate instruction and data memories. It holds the winning request through a variable-latency req/ack memory handshake and returns per-port ready pulses, which the pipeline uses as PC and IF/ID hold conditions. Data accesses win by default, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending; must be ≥1
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; registered
- if_ready  out  1  one-cycle fetch completion pulse
- dm_read  in  1  data read request
- dm_write  in  1  data write request
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data; registered
- dm_ready  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- err  out  1  sticky protocol error

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: mem_req=1, wait for mem_ack.
  - RESP: pulse ready, then return to IDLE.
- Arbitration in IDLE:
  - Data is pending when dm_read|dm_write.
  - Data only → grant DM.
  - Fetch only → grant IF.
  - Both pending → grant DM, unless starve_cnt==STARVE_MAX, in which case grant IF.
  - Neither pending → stay in IDLE.
- On grant: latch the port, address, write data and we (we = dm_write for DM, 0 for IF) into the issue registers, then go to BUSY. mem_addr, mem_wdata and mem_we are driven only from these registers, never combinationally from the requesters.
- BUSY with mem_ack: capture mem_rdata into if_rdata (IF reads) or dm_rdata (DM reads), then go to RESP. DM writes leave dm_rdata unchanged.
- RESP: the granted port's ready=1 for exactly one cycle. Requests are ignored. Next state is IDLE.
- Starvation counter starve_cnt:
  - Increments on a DM grant while if_req=1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Clears on a DM grant with if_req=0.
- dm_read & dm_write both high at arbitration: treated as a write and err set. err clears only on reset.
- mem_ack outside BUSY is ignored.
- Requesters must keep address and data stable until ready. The arbiter samples them only at grant, so later changes do not affect an access already in flight.

## Timing
- Reset (asynchronous, immediate) values:
  - State IDLE.
  - mem_req, mem_we, if_ready, dm_ready, err = 0.
  - if_rdata, dm_rdata, mem_addr, mem_wdata = 0.
  - starve_cnt = 0.
- Reset during BUSY drops mem_req immediately. The outstanding access is abandoned, and a late mem_ack arriving after reset is ignored.
- Cycle-level sequence:
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: mem_req high.
  - Cycle k≥1: mem_ack.
  - Cycle k+1: ready pulse.
  - Cycle k+2: IDLE arbitrates again.
- Minimum access is 3 cycles (mem_ack in cycle 1). Back-to-back accesses, same or alternating port, are spaced every k+2 cycles.
- The ready pulse and the captured rdata appear in the same cycle. rdata then holds until that port's next read completes.

## Structure
- Package mem_arb_pkg holds:
  - State enum: ARB_IDLE, ARB_BUSY, ARB_RESP.
  - Grant encoding: GNT_IF, GNT_DM.
  - Counter width function: clog2(STARVE_MAX+1).
- One natural sub-module, arb_starve_cnt, implements the saturating starvation counter with inc/clr/sat ports. The FSM and issue registers live in mem_arbiter.

## Test plan
- Fetch only: if_req=1, if_addr=0x40, mem_ack in cycle 3 with mem_rdata=0x8C080004 → mem_req high in cycles 1–3 with mem_addr=0x40 and mem_we=0; if_ready pulses in cycle 4; if_rdata=0x8C080004.
- Write then read: dm_write to 0x100 with 0xDEADBEEF, then dm_read of 0x100 with memory returning 0xDEADBEEF → first access has mem_we=1 and mem_wdata=0xDEADBEEF, and dm_rdata stays 0 after it; dm_rdata=0xDEADBEEF after the second dm_ready.
- Contention, STARVE_MAX=4: if_req and dm_read held continuously, immediate acks → grant order DM,DM,DM,DM,IF, repeating.
- Protocol error: dm_read=dm_write=1 → write issued (mem_we=1) and err=1; err stays 1 until reset_n pulses low.
- Reset mid-access: reset_n low in BUSY → mem_req=0 in the same cycle; a mem_ack after release produces no ready; a fresh fetch completes normally.
- Spurious ack: mem_ack while IDLE → no state change; no ready pulse; rdata registers unchanged.
